// File: rtl/time_sync_pkg.sv
// Shared types and default sizing for the time synchronisation controller.
package time_sync_pkg;

  localparam int DEF_CNT_WIDTH = 64;
  localparam int DEF_US_CYCLE  = 512;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_IDLE      = 2'd1,
    ST_ARMED     = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with a third flop for rising-edge detection.
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Both terms come straight from flops, so the pulse is glitch-free.
  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q;

endmodule

// File: rtl/time_sync_ctrl.sv
// System time counter that loads an armed timestamp on the next SYNC0 edge
// and exposes the phase within the ultrasound period.
module time_sync_ctrl
  import time_sync_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int US_CYCLE  = DEF_US_CYCLE,
  localparam int US_W     = $clog2(US_CYCLE)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 LOCKED,
  input  logic                 SYNC,
  input  logic [CNT_WIDTH-1:0] SYNC_TIME,
  input  logic                 SET_REQ,
  output logic                 SET_ACK,
  output logic [CNT_WIDTH-1:0] TIME_CNT,
  output logic [US_W-1:0]      US_CNT,
  output logic                 CYCLE_START,
  output logic                 RUNNING
);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] time_q, time_d;
  logic [CNT_WIDTH-1:0] latch_q, latch_d;
  logic                 ack_q, ack_d;

  logic lock_s, lock_rise;
  logic sync_s, sync_rise;

  sync_edge_det u_lock_sync (
    .clk_i   (CLK),
    .rst_i   (RST),
    .d_i     (LOCKED),
    .level_o (lock_s),
    .rise_o  (lock_rise)
  );

  sync_edge_det u_sync_det (
    .clk_i   (CLK),
    .rst_i   (RST),
    .d_i     (SYNC),
    .level_o (sync_s),
    .rise_o  (sync_rise)
  );

  wire [CNT_WIDTH-1:0] time_inc = time_q + CNT_WIDTH'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_WAIT_LOCK;
      time_q  <= '0;
      latch_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      latch_q <= latch_d;
      ack_q   <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    latch_d = latch_q;
    ack_d   = 1'b0;
    case (state_q)
      // Synchronized LOCKED is always 0 the cycle before we sit here, so its
      // rise coincides exactly with the first cycle it reads 1.
      ST_WAIT_LOCK: begin
        time_d = '0;
        if (lock_rise) state_d = ST_IDLE;
      end
      ST_IDLE, ST_RUN: begin
        time_d = time_inc;
        if (SET_REQ) begin
          latch_d = SYNC_TIME;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (sync_rise) begin
          time_d  = latch_q;
          ack_d   = 1'b1;
          state_d = ST_RUN;
        end else begin
          time_d = time_inc;
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        time_d  = '0;
      end
    endcase
    // Lock loss overrides everything, including a coincident SYNC edge.
    if (!lock_s) begin
      state_d = ST_WAIT_LOCK;
      time_d  = '0;
      ack_d   = 1'b0;
    end
  end

  assign SET_ACK     = ack_q;
  assign TIME_CNT    = time_q;
  assign US_CNT      = time_q[US_W-1:0];
  assign RUNNING     = (state_q != ST_WAIT_LOCK);
  assign CYCLE_START = (US_CNT == '0) && RUNNING;

  logic unused_sync_level;
  assign unused_sync_level = sync_s;

endmodule

// File: tb/tb_time_sync_ctrl.sv
// Directed bench for time_sync_ctrl: lock-up, wrap, SYNC load, lock loss, reset abort.
module tb_time_sync_ctrl;

  logic        CLK = 1'b0;
  logic        RST, LOCKED, SYNC, SET_REQ;
  logic [63:0] SYNC_TIME;
  logic        SET_ACK, CYCLE_START, RUNNING;
  logic [63:0] TIME_CNT;
  logic [8:0]  US_CNT;

  int checks   = 0;
  int failures = 0;

  time_sync_ctrl dut (
    .CLK         (CLK),
    .RST         (RST),
    .LOCKED      (LOCKED),
    .SYNC        (SYNC),
    .SYNC_TIME   (SYNC_TIME),
    .SET_REQ     (SET_REQ),
    .SET_ACK     (SET_ACK),
    .TIME_CNT    (TIME_CNT),
    .US_CNT      (US_CNT),
    .CYCLE_START (CYCLE_START),
    .RUNNING     (RUNNING)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    int pulses;
    logic ack_seen;

    RST = 1'b1; LOCKED = 1'b0; SYNC = 1'b0; SET_REQ = 1'b0; SYNC_TIME = '0;
    step(2);
    RST = 1'b0;
    step(50);
    chk("rst_time", TIME_CNT, 0);
    chk("rst_us", US_CNT, 0);
    chk("rst_running", RUNNING, 0);
    chk("rst_ack", SET_ACK, 0);
    chk("rst_cs", CYCLE_START, 0);

    // Lock-up: RUNNING after the third edge, then count 0,1,2
    LOCKED = 1'b1;
    step(2);
    chk("lock_e2_running", RUNNING, 0);
    step();
    chk("lock_e3_running", RUNNING, 1);
    chk("lock_e3_time", TIME_CNT, 0);
    chk("lock_e3_cs", CYCLE_START, 1);
    step();
    chk("count_1", TIME_CNT, 1);
    chk("count_1_cs", CYCLE_START, 0);
    step();
    chk("count_2", TIME_CNT, 2);

    // Ultrasound period wrap
    step(509);
    chk("t511_us", US_CNT, 511);
    chk("t511_cs", CYCLE_START, 0);
    step();
    chk("t512_us", US_CNT, 0);
    chk("t512_cs", CYCLE_START, 1);
    pulses = 0;
    for (int i = 0; i < 512; i++) begin
      step();
      if (CYCLE_START) pulses++;
    end
    chk("cs_once_per_period", pulses, 1);
    chk("t1024", TIME_CNT, 1024);

    // SYNC in IDLE without a request: no effect
    ack_seen = 1'b0;
    SYNC = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (SET_ACK) ack_seen = 1'b1;
      if (i == 2) SYNC = 1'b0;
    end
    chk("idle_sync_no_ack", ack_seen, 0);
    chk("idle_sync_time", TIME_CNT, 1030);

    // Armed load; SYNC_TIME change while armed must be ignored
    SET_REQ = 1'b1; SYNC_TIME = 64'h1000_0000_0000_01FE;
    step();
    chk("arm_time", TIME_CNT, 1031);
    SYNC_TIME = 64'h0000_0000_0000_DEAD;
    step();
    SYNC = 1'b1;
    step(2);
    chk("load_e2_time", TIME_CNT, 1034);
    chk("load_e2_ack", SET_ACK, 0);
    step();
    chk("load_e3_time", TIME_CNT, 64'h1000_0000_0000_01FE);
    chk("load_e3_ack", SET_ACK, 1);
    SET_REQ = 1'b0; SYNC = 1'b0;
    step();
    chk("load_p1_time", TIME_CNT, 64'h1000_0000_0000_01FF);
    chk("load_p1_ack", SET_ACK, 0);
    chk("load_p1_cs", CYCLE_START, 0);
    step();
    chk("load_p2_time", TIME_CNT, 64'h1000_0000_0000_0200);
    chk("load_p2_cs", CYCLE_START, 1);

    // Lock loss coinciding with the detected SYNC edge
    SET_REQ = 1'b1; SYNC_TIME = 64'h55;
    step();
    SYNC = 1'b1; LOCKED = 1'b0;
    step(2);
    chk("lol_e2_running", RUNNING, 1);
    chk("lol_e2_time", TIME_CNT, 64'h1000_0000_0000_0203);
    step();
    chk("lol_e3_running", RUNNING, 0);
    chk("lol_e3_time", TIME_CNT, 0);
    chk("lol_e3_us", US_CNT, 0);
    chk("lol_e3_ack", SET_ACK, 0);
    SET_REQ = 1'b0;
    step();
    chk("lol_e4_ack", SET_ACK, 0);
    SYNC = 1'b0;

    // All-ones load wraps to zero
    LOCKED = 1'b1;
    step(3);
    chk("relock_running", RUNNING, 1);
    chk("relock_time", TIME_CNT, 0);
    SET_REQ = 1'b1; SYNC_TIME = '1;
    step();
    SYNC = 1'b1;
    step(3);
    chk("ones_load_time", TIME_CNT, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ones_load_ack", SET_ACK, 1);
    SET_REQ = 1'b0; SYNC = 1'b0;
    step();
    chk("ones_wrap_time", TIME_CNT, 0);
    chk("ones_wrap_us", US_CNT, 0);
    chk("ones_wrap_cs", CYCLE_START, 1);

    // Reset while armed aborts the load
    step(3);
    SET_REQ = 1'b1; SYNC_TIME = 64'h5;
    step();
    SYNC = 1'b1;
    step();
    RST = 1'b1;
    step();
    chk("rst_armed_running", RUNNING, 0);
    chk("rst_armed_time", TIME_CNT, 0);
    chk("rst_armed_ack", SET_ACK, 0);
    RST = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (SET_ACK) ack_seen = 1'b1;
    end
    chk("rst_armed_no_ack", ack_seen, 0);
    chk("rst_armed_after_time", TIME_CNT, 3);
    chk("rst_armed_after_running", RUNNING, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
